// File: rtl/main_memory_ctrl_if.sv
// Bus-side signal bundle for main_memory_ctrl: request pulses in, read responses
// and status out. The master side is the coherence bus; the slave side is the memory.
interface main_memory_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     mem_req_valid;
  logic                     mem_req_write;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic                     mem_resp_valid;
  logic [DATA_WIDTH-1:0]    mem_resp_data;
  logic                     busy;
  logic                     fifo_overflow;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  mem_resp_valid, mem_resp_data, busy, fifo_overflow
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output mem_resp_valid, mem_resp_data, busy, fifo_overflow
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Main-memory model and in-order request controller. Requests are queued in a
// small FIFO, writes retire in one cycle, reads return after READ_LATENCY wait
// cycles as a single registered response pulse.
module main_memory_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  main_memory_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WORDS = 2 ** ADDRESS_WIDTH;

  typedef enum logic {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

  // request FIFO payload and pointers (extra MSB separates full from empty)
  logic                     fifo_write_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;

  // storage array
  logic [DATA_WIDTH-1:0]    storage_q [WORDS];

  // controller state
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;

  // response path
  logic                     stage_q, stage_d;
  logic [DATA_WIDTH-1:0]    stage_data_q, stage_data_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;

  // status
  logic                     overflow_q, overflow_d;
  logic                     busy_q, busy_d;

  // combinational helpers
  logic                     fifo_empty, fifo_full;
  logic                     push, pop, mem_we;
  logic                     head_write;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign head_write = fifo_write_q[rd_ptr_q[IDX_W-1:0]];
  assign head_addr  = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
  assign head_data  = fifo_data_q[rd_ptr_q[IDX_W-1:0]];

  // FSM next state: pop head when idle, count down read latency
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    raddr_d      = raddr_q;
    pop          = 1'b0;
    mem_we       = 1'b0;
    stage_d      = 1'b0;
    stage_data_d = stage_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_write) begin
            mem_we = 1'b1;
          end else begin
            raddr_d = head_addr;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          // Read data is captured here and presented one edge later through the
          // output register; the controller is already free to pop on that edge,
          // so throughput stays one read per READ_LATENCY+1 cycles.
          stage_d      = 1'b1;
          stage_data_d = storage_q[raddr_q];
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer update, overflow detection, response and busy next values
  always_comb begin
    push         = bus.mem_req_valid && (!fifo_full || pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    overflow_d   = overflow_q | (bus.mem_req_valid && fifo_full && !pop);
    resp_valid_d = stage_q;
    resp_data_d  = stage_q ? stage_data_q : resp_data_q;
    busy_d       = (wr_ptr_d != rd_ptr_d) || (state_d != IDLE) || stage_d;
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      raddr_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stage_q      <= 1'b0;
      stage_data_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      raddr_q      <= raddr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stage_q      <= stage_d;
      stage_data_q <= stage_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO payload write; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_write_q[wr_ptr_q[IDX_W-1:0]] <= bus.mem_req_write;
      fifo_addr_q[wr_ptr_q[IDX_W-1:0]]  <= bus.mem_req_addr;
      fifo_data_q[wr_ptr_q[IDX_W-1:0]]  <= bus.mem_req_data;
    end
  end

  // storage array: cleared on reset, written when a write request retires
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        storage_q[i] <= '0;
      end
    end else if (mem_we) begin
      storage_q[head_addr] <= head_data;
    end
  end

  assign bus.mem_resp_valid = resp_valid_q;
  assign bus.mem_resp_data  = resp_data_q;
  assign bus.busy           = busy_q;
  assign bus.fifo_overflow  = overflow_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: stimulus pushes expected read data and
// the cycle it must appear; a monitor pops and compares on every response pulse.
module tb_main_memory_ctrl;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  main_memory_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  main_memory_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .READ_LATENCY(LAT),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // monitor: every response pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: pulse at cycle %0d data %0h, required no pulse",
                   cyc, bus.mem_resp_data);
        end else begin
          e = sb.pop_front();
          check("resp_data", bus.mem_resp_data, e.data);
          check("resp_cycle", DW'(cyc), DW'(e.at));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output int e);
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_write = w;
    bus.mem_req_addr  = a;
    bus.mem_req_data  = d;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.mem_req_valid = 1'b0;
    end
  endtask

  task automatic expect_rd(input logic [DW-1:0] d, input int at);
    sb.push_back('{data: d, at: at});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    idle(8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int e, e0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_resp_valid", bus.mem_resp_valid, 0);
    check("rst_resp_data", bus.mem_resp_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.fifo_overflow, 0);

    // single read of cleared storage
    req(0, 5, 32'h0, e);
    expect_rd(32'h0, e + 6);
    idle(1);
    check("busy_rise", bus.busy, 1);
    drain();

    // write then read back to back
    req(1, 3, 32'hDEADBEEF, e);
    req(0, 3, 32'h0, e0);
    expect_rd(32'hDEADBEEF, e + 7);
    idle(1);
    drain();

    // in-order reads, 5 cycles apart
    for (int i = 0; i < 4; i++) begin
      req(1, AW'(i + 1), DW'((i + 1) * 32'h11), e);
      if (i == 0) e0 = e;
    end
    for (int i = 0; i < 4; i++) begin
      req(0, AW'(4 - i), 32'h0, e);
      expect_rd(DW'((4 - i) * 32'h11), e0 + 10 + 5 * i);
    end
    idle(1);
    wait_cyc(e0 + 12);
    check("busy_mid", bus.busy, 1);
    wait_cyc(e0 + 27);
    check("busy_fall", bus.busy, 0);
    drain();

    // overflow: six reads into a four-entry FIFO
    for (int i = 0; i < 6; i++) req(1, AW'(10 + i), DW'(32'h100 + 10 + i), e);
    idle(1);
    drain();
    for (int i = 0; i < 6; i++) begin
      req(0, AW'(10 + i), 32'h0, e);
      if (i == 0) e0 = e;
      if (i == 5) check("overflow_before", bus.fifo_overflow, 0);
      if (i < 5) expect_rd(DW'(32'h100 + 10 + i), e0 + 6 + 5 * i);
    end
    idle(1);
    check("overflow_set", bus.fifo_overflow, 1);
    drain();
    check("overflow_sticky", bus.fifo_overflow, 1);

    // full FIFO with push and pop on the same edge
    do_reset();
    check("overflow_cleared", bus.fifo_overflow, 0);
    for (int i = 0; i < 6; i++) req(1, AW'(20 + i), DW'(32'hC0DE0000 + 20 + i), e);
    idle(1);
    drain();
    req(0, 20, 32'h0, e0);
    expect_rd(32'hC0DE0014, e0 + 6);
    for (int i = 1; i < 5; i++) begin
      req(0, AW'(20 + i), 32'h0, e);
      expect_rd(DW'(32'hC0DE0000 + 20 + i), e0 + 6 + 5 * i);
    end
    idle(1);
    req(0, 25, 32'h0, e);
    check("full_push_edge", DW'(e), DW'(e0 + 6));
    expect_rd(32'hC0DE0019, e0 + 31);
    idle(1);
    drain();
    check("full_no_overflow", bus.fifo_overflow, 0);

    // reset during READ_WAIT discards the read; request during reset is dropped
    req(1, 7, 32'hA5A5A5A5, e0);
    req(0, 7, 32'h0, e);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = 7;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_req_valid = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_overflow", bus.fifo_overflow, 0);
    check("midrst_resp_data", bus.mem_resp_data, 0);
    check("midrst_resp_valid", bus.mem_resp_valid, 0);
    idle(12);
    check("midrst_busy_later", bus.busy, 0);
    req(0, 7, 32'h0, e);
    expect_rd(32'h0, e + 6);
    idle(1);
    drain();
    check("final_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Main-memory model and request controller sitting directly downstream of the coherence bus. It accepts single-cycle memory request pulses from the bus (reads and write-throughs), buffers them in an in-order request FIFO, and services them against a word-addressed storage array. Reads return data after a programmable latency as a single-cycle response pulse, which the bus then broadcasts to the caches.

## Interface
- ADDRESS_WIDTH, 6, word address width; storage holds 2**ADDRESS_WIDTH words
- DATA_WIDTH, 32, data word width
- READ_LATENCY, 4, wait cycles between read pop and response; legal range 1..15
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2

- clk  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- mem_req_valid  input  1  request pulse from bus; no backpressure
- mem_req_write  input  1  1 = write, 0 = read
- mem_req_addr  input  ADDRESS_WIDTH  word address
- mem_req_data  input  DATA_WIDTH  write data; ignored for reads
- mem_resp_valid  output  1  one-cycle read-data pulse to bus
- mem_resp_data  output  DATA_WIDTH  read data; holds last value between pulses
- busy  output  1  FIFO non-empty or state != IDLE
- fifo_overflow  output  1  sticky; a request was dropped because the FIFO was full

## Operation
- The FIFO entry holds {write, addr, data}. A push occurs at every edge where mem_req_valid=1.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Write: storage[addr] <= data at the same edge; stay IDLE.
    - Read: latch addr, cnt <= READ_LATENCY-1, go to READ_WAIT.
  - READ_WAIT: no pops.
    - If cnt == 0: mem_resp_data <= storage[latched addr], mem_resp_valid <= 1, go to IDLE.
    - Otherwise cnt <= cnt-1.
- mem_resp_valid is registered and asserted for exactly one cycle per read.
- Requests are serviced strictly in arrival order, so read-after-write to the same address returns the new data.
- FIFO full/empty:
  - Push and pop at the same edge are both honoured, including when full.
  - Push when full with no pop: request dropped, fifo_overflow <= 1, FIFO contents unchanged.
  - Pop never occurs when empty.
- Pointers are log2(FIFO_DEPTH)+1 bits so full and empty are distinguishable on wrap-around.
- On reset:
  - FIFO emptied; state IDLE; cnt 0.
  - mem_resp_valid 0, mem_resp_data 0, fifo_overflow 0, busy 0.
  - All storage words cleared to 0.
  - An in-flight read is discarded and produces no response.
  - A request presented in the same cycle as reset is not accepted.

## Timing
- Request sampled at edge E is enqueued at E. Earliest pop is at E+1 (no fall-through).
- Read with an idle controller and empty FIFO: popped at E+1, response registered at E+2+READ_LATENCY, so mem_resp_valid is high in the cycle after that edge. For example, READ_LATENCY=4 gives a response at E+6.
- Write with an idle controller: storage updated at E+1. A read popped at E+2 or later sees the new data.
- After a read response, the next pop occurs at the following edge at the earliest. Read throughput is one per READ_LATENCY+1 cycles; write throughput is one per cycle.
- busy rises in the cycle after the first push and falls in the cycle after the edge where the FIFO is empty and the state returns to IDLE.
- Every output is driven from a register. There are no combinational paths from input to output.

## Test plan
- **Reset, then single read.** Reset, then a read of addr 5 at edge E with READ_LATENCY=4. Expect mem_resp_valid high for exactly one cycle, registered at E+6, with mem_resp_data=0. No other pulse follows.
- **Write then read, back to back.** Write addr 3 = 0xDEADBEEF at E, then read addr 3 at E+1. Expect a single response registered at E+7 with data 0xDEADBEEF. The write itself produces no response pulse.
- **In-order reads.** Write addrs 1..4 = 0x11, 0x22, 0x33, 0x44, then read addrs 4, 3, 2, 1 on consecutive cycles. Expect responses 0x44, 0x33, 0x22, 0x11 in that order, 5 cycles apart; busy stays high throughout and drops after the last response.
- **Overflow.** With FIFO_DEPTH=4, issue 6 reads on consecutive edges E..E+5 (addrs 10..15). Expect the addr-15 request to be dropped and fifo_overflow to go high after E+5 and remain high. Exactly 5 responses follow, for addrs 10..14.
- **Full push+pop.** Fill the FIFO to 4 entries while a read is in READ_WAIT. Push at the exact edge where the controller pops. Expect the push to be accepted, fifo_overflow to stay 0, and all requests to be serviced.
- **Reset mid-operation.** Write addr 7 = 0xA5A5A5A5, issue a read of addr 7, and assert reset for one cycle during READ_WAIT. Expect no response pulse, and busy=0, fifo_overflow=0, mem_resp_data=0 after reset. A subsequent read of addr 7 returns 0.
